// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory controller.
package main_mem_pkg;

    localparam int MM_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mm_state_t;

endpackage

// File: rtl/main_mem_ctrl_sp_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The read register only updates on enabled reads, so it holds the last read word.
module sp_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[idx] <= wdata;
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: one single-word read or write per request,
// completed LATENCY cycles after acceptance with a one-cycle mem_ready pulse.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mem_access,
    input  logic        mem_write,
    input  logic [31:0] mem_a,
    input  logic [31:0] mem_st_data,
    output logic [31:0] mem_data,
    output logic        mem_ready
);

    localparam bit                    FAST     = (LATENCY == 1);
    localparam logic [MM_CNT_W-1:0]   CNT_INIT = MM_CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    mm_state_t               state_q, state_d;
    logic [MM_CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   req_idx_q, req_idx_d;
    logic                    req_write_q, req_write_d;
    logic [31:0]             req_data_q, req_data_d;
    logic                    ready_q, ready_d;
    logic [31:0]             mem_data_q, mem_data_d;

    logic                    ram_en;
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_idx;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;

    logic [DEPTH_LOG2-1:0]   in_idx;
    logic                    unused_addr_bits;

    assign in_idx           = mem_a[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{mem_a[31:DEPTH_LOG2+2], mem_a[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_idx_d   = req_idx_q;
        req_write_d = req_write_q;
        req_data_d  = req_data_q;
        ready_d     = 1'b0;
        mem_data_d  = mem_data_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_idx     = req_idx_q;
        ram_wdata   = req_data_q;

        case (state_q)
            IDLE: begin
                if (mem_access) begin
                    req_idx_d   = in_idx;
                    req_write_d = mem_write;
                    req_data_d  = mem_st_data;
                    if (FAST) begin
                        // With single-cycle latency the commit edge is the accept edge,
                        // so the RAM must see the live inputs rather than the latches.
                        state_d   = READY;
                        ready_d   = 1'b1;
                        ram_en    = 1'b1;
                        ram_we    = mem_write;
                        ram_idx   = in_idx;
                        ram_wdata = mem_st_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_access) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = READY;
                    ready_d = 1'b1;
                    ram_en  = 1'b1;
                    ram_we  = req_write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READY: begin
                state_d = IDLE;
                if (!req_write_q) begin
                    mem_data_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_idx_q   <= '0;
            req_write_q <= 1'b0;
            req_data_q  <= '0;
            ready_q     <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_idx_q   <= req_idx_d;
            req_write_q <= req_write_d;
            req_data_q  <= req_data_d;
            ready_q     <= ready_d;
            mem_data_q  <= mem_data_d;
        end
    end

    sp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM read register carries the word during READY; mem_data_q keeps it afterwards.
    assign mem_data  = (state_q == READY && !req_write_q) ? ram_rdata : mem_data_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl with a LATENCY=4 and a LATENCY=1 instance.
module tb_main_mem_ctrl;
    import main_mem_pkg::*;

    logic        clk;
    logic        clr;
    logic        acc4, wr4, rdy4;
    logic [31:0] a4, d4, data4;
    logic        acc1, wr1, rdy1;
    logic [31:0] a1, d1, data1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    main_mem_ctrl #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (
        .clk(clk), .clr(clr), .mem_access(acc4), .mem_write(wr4), .mem_a(a4),
        .mem_st_data(d4), .mem_data(data4), .mem_ready(rdy4)
    );

    main_mem_ctrl #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .clr(clr), .mem_access(acc1), .mem_write(wr1), .mem_a(a1),
        .mem_st_data(d1), .mem_data(data1), .mem_ready(rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input bit s);
        return s ? rdy1 : rdy4;
    endfunction

    function automatic logic [31:0] data_of(input bit s);
        return s ? data1 : data4;
    endfunction

    task automatic drive(input bit s, input logic acc, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            acc1 = acc; wr1 = w; a1 = a; d1 = d;
        end else begin
            acc4 = acc; wr4 = w; a4 = a; d4 = d;
        end
    endtask

    // Issue one request, measure cycles to mem_ready, capture mem_data in that cycle.
    task automatic request(input bit s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat, input string name,
                           output logic [31:0] rd);
        int got;
        got = 0;
        rd  = 'x;
        drive(s, 1'b1, w, a, d);
        for (int i = 1; i <= exp_lat + 3 && got == 0; i++) begin
            step();
            if (rdy_of(s) === 1'b1) begin
                got = i;
                rd  = data_of(s);
            end
        end
        drive(s, 1'b0, w, a, d);
        total_cnt++;
        if (got !== exp_lat)
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, got, exp_lat);
        else
            pass_cnt++;
        if (got != 0) begin
            step();
            total_cnt++;
            if (rdy_of(s) !== 1'b0)
                $display("FAIL %s_pulse_width: mem_ready=%b, expected 0", name, rdy_of(s));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        clr = 1'b0;
        step();
        total_cnt++;
        if (rdy4 !== 1'b0) $display("FAIL reset_ready4: %b expected 0", rdy4); else pass_cnt++;
        total_cnt++;
        if (data4 !== 32'h0) $display("FAIL reset_data4: %h expected 0", data4); else pass_cnt++;
        total_cnt++;
        if (dut4.state_q !== IDLE) $display("FAIL reset_state4: %0d expected IDLE", dut4.state_q); else pass_cnt++;
        total_cnt++;
        if (rdy1 !== 1'b0) $display("FAIL reset_ready1: %b expected 0", rdy1); else pass_cnt++;
        total_cnt++;
        if (data1 !== 32'h0) $display("FAIL reset_data1: %h expected 0", data1); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        request(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4, "wr40", rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL wr40_data: mem_data=%h expected 00000000", rd); else pass_cnt++;
        request(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4, "rd40", rd);
        total_cnt++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL rd40_data: %h expected deadbeef", rd); else pass_cnt++;
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        request(1'b0, 1'b1, 32'h0000_1040, 32'h1234_5678, 4, "wr1040", rd);
        total_cnt++;
        if (data4 !== 32'hDEAD_BEEF) $display("FAIL hold_after_write: %h expected deadbeef", data4); else pass_cnt++;
        request(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4, "rd_alias", rd);
        total_cnt++;
        if (rd !== 32'h1234_5678) $display("FAIL alias_data: %h expected 12345678", rd); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int seen;
        request(1'b0, 1'b1, 32'h0000_0080, 32'h1111_2222, 4, "wr80", rd);
        seen = 0;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        step();
        if (rdy4 === 1'b1) seen++;
        step();
        if (rdy4 === 1'b1) seen++;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        for (int i = 0; i < 6; i++) begin
            step();
            if (rdy4 === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL abort_no_ready: %0d pulses expected 0", seen); else pass_cnt++;
        total_cnt++;
        if (data4 !== 32'h1234_5678) $display("FAIL abort_data_hold: %h expected 12345678", data4); else pass_cnt++;
        request(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4, "rd80", rd);
        total_cnt++;
        if (rd !== 32'h1111_2222) $display("FAIL abort_array: %h expected 11112222", rd); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        request(1'b1, 1'b1, 32'h0000_0000, 32'hAAAA_0000, 1, "l1_wr0", rd);
        request(1'b1, 1'b1, 32'h0000_0004, 32'hBBBB_0004, 1, "l1_wr4", rd);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        step();
        total_cnt++;
        if (rdy1 !== 1'b1 || data1 !== 32'hAAAA_0000)
            $display("FAIL b2b_first: ready=%b data=%h expected 1/aaaa0000", rdy1, data1);
        else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        step();
        total_cnt++;
        if (rdy1 !== 1'b0) $display("FAIL b2b_gap: ready=%b expected 0", rdy1); else pass_cnt++;
        step();
        total_cnt++;
        if (rdy1 !== 1'b1 || data1 !== 32'hBBBB_0004)
            $display("FAIL b2b_second: ready=%b data=%h expected 1/bbbb0004", rdy1, data1);
        else pass_cnt++;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0);
        step();
        total_cnt++;
        if (rdy1 !== 1'b0 || data1 !== 32'hBBBB_0004)
            $display("FAIL b2b_end: ready=%b data=%h expected 0/bbbb0004", rdy1, data1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        int seen;
        request(1'b0, 1'b1, 32'h0000_00C0, 32'h5566_7788, 4, "wrC0", rd);
        seen = 0;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_00C0, 32'hCAFE_F00D);
        step();
        step();
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        total_cnt++;
        if (dut4.state_q !== IDLE) $display("FAIL clr_async_state: %0d expected IDLE", dut4.state_q); else pass_cnt++;
        step();
        step();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rdy4 === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL clr_no_ready: %0d pulses expected 0", seen); else pass_cnt++;
        total_cnt++;
        if (data4 !== 32'h0) $display("FAIL clr_data: %h expected 0", data4); else pass_cnt++;
        request(1'b0, 1'b0, 32'h0000_00C0, 32'h0, 4, "rdC0", rd);
        total_cnt++;
        if (rd !== 32'h5566_7788) $display("FAIL clr_no_write: %h expected 55667788", rd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_abort();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
